// File: rtl/uart_frame_shifter_if.sv
// Parallel/serial handshake bundle for uart_frame_shifter.
// master drives the transmit word and strobes; slave is the shifter itself.
interface uart_frame_shifter_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data;
  logic              load;
  logic              shift;
  logic              shift_in;
  logic              tx_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] data_received;
  logic              rx_parity_err;
  logic              rx_framing_err;

  modport master (
    output data, load, shift, shift_in,
    input  tx_data, busy, done, data_received, rx_parity_err, rx_framing_err
  );

  modport slave (
    input  data, load, shift, shift_in,
    output tx_data, busy, done, data_received, rx_parity_err, rx_framing_err
  );
endinterface

// File: rtl/uart_frame_shifter.sv
// UART frame shifter: serialises one start/data/parity/stop frame LSB first
// while shifting a frame in from shift_in, then checks the captured frame.
module uart_frame_shifter #(
  parameter int DATA_W    = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  uart_frame_shifter_if.slave  bus
);

  localparam int   PAR_W   = (PARITY != 0) ? 1 : 0;
  localparam int   FRAME_W = 1 + DATA_W + PAR_W + STOP_BITS;
  localparam int   CNT_W   = $clog2(FRAME_W + 1);
  localparam logic ODD_PAR = (PARITY == 2);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_reg, state_next;
  logic [FRAME_W-1:0] frame_reg, frame_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               done_reg;
  logic [DATA_W-1:0]  data_received_reg;
  logic               rx_parity_err_reg;
  logic               rx_framing_err_reg;

  logic               load_accept;
  logic               shift_accept;
  logic               last_shift;
  logic [FRAME_W-1:0] load_frame;
  logic [FRAME_W-1:0] shifted_frame;
  logic               rx_parity_bad;
  logic               rx_framing_bad;
  logic [STOP_BITS-1:0] stop_ok;
  logic               tx_bit;
  logic               busy_bit;

  // Load beats shift in IDLE; in SHIFT only the strobe matters.
  assign load_accept   = (state_reg == IDLE)  && bus.load;
  assign shift_accept  = (state_reg == SHIFT) && bus.shift;
  assign last_shift    = shift_accept && (cnt_reg == CNT_W'(FRAME_W - 1));
  assign shifted_frame = {bus.shift_in, frame_reg[FRAME_W-1:1]};

  generate
    if (PAR_W == 1) begin : g_parity
      logic tx_par;
      assign tx_par        = (^bus.data) ^ ODD_PAR;
      assign load_frame    = {{STOP_BITS{1'b1}}, tx_par, bus.data, 1'b0};
      assign rx_parity_bad = shifted_frame[DATA_W+1] ^ (^shifted_frame[DATA_W:1]) ^ ODD_PAR;
    end else begin : g_no_parity
      assign load_frame    = {{STOP_BITS{1'b1}}, bus.data, 1'b0};
      assign rx_parity_bad = 1'b0;
    end
  endgenerate

  // Stop bits occupy the top of the frame, outermost last.
  generate
    for (genvar gi = 0; gi < STOP_BITS; gi++) begin : g_stop
      assign stop_ok[gi] = shifted_frame[FRAME_W-1-gi];
    end
  endgenerate

  assign rx_framing_bad = shifted_frame[0] | ~(&stop_ok);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (load_accept) state_next = SHIFT;
      SHIFT:   if (last_shift)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_bit   = 1'b1;
    busy_bit = 1'b0;
    if (state_reg == SHIFT) begin
      tx_bit   = frame_reg[0];
      busy_bit = 1'b1;
    end
  end

  always_comb begin
    frame_next = frame_reg;
    cnt_next   = cnt_reg;
    if (load_accept) begin
      frame_next = load_frame;
      cnt_next   = '0;
    end else if (shift_accept) begin
      frame_next = shifted_frame;
      cnt_next   = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frame_reg <= '1;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      frame_reg <= frame_next;
      cnt_reg   <= cnt_next;
      done_reg  <= last_shift;
    end
  end

  // Captured results follow the post-shift frame and hold until the next completion.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_received_reg  <= '0;
      rx_parity_err_reg  <= 1'b0;
      rx_framing_err_reg <= 1'b0;
    end else if (last_shift) begin
      data_received_reg  <= shifted_frame[DATA_W:1];
      rx_parity_err_reg  <= rx_parity_bad;
      rx_framing_err_reg <= rx_framing_bad;
    end
  end

  assign bus.tx_data        = tx_bit;
  assign bus.busy           = busy_bit;
  assign bus.done           = done_reg;
  assign bus.data_received  = data_received_reg;
  assign bus.rx_parity_err  = rx_parity_err_reg;
  assign bus.rx_framing_err = rx_framing_err_reg;

endmodule

// File: tb/tb_uart_frame_shifter.sv
// Loopback bench for uart_frame_shifter: three configurations, expected
// received results queued at load time and checked when done pulses.
module tb_uart_frame_shifter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data  = 8'h00;
  logic       load  = 1'b0;
  logic       shift = 1'b0;
  logic       flip  = 1'b0;
  int         sel   = 0;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [7:0] dr;
    logic       pe;
    logic       fe;
  } exp_t;
  exp_t exp_q[$];

  always #5 clock = ~clock;

  uart_frame_shifter_if #(.DATA_W(8)) bus_e ();
  uart_frame_shifter_if #(.DATA_W(8)) bus_o ();
  uart_frame_shifter_if #(.DATA_W(8)) bus_2 ();

  assign bus_e.data = data;
  assign bus_o.data = data;
  assign bus_2.data = data;
  assign bus_e.load = load & (sel == 0);
  assign bus_o.load = load & (sel == 1);
  assign bus_2.load = load & (sel == 2);
  assign bus_e.shift = shift;
  assign bus_o.shift = shift;
  assign bus_2.shift = shift;
  assign bus_e.shift_in = bus_e.tx_data ^ flip;
  assign bus_o.shift_in = bus_o.tx_data ^ flip;
  assign bus_2.shift_in = bus_2.tx_data ^ flip;

  uart_frame_shifter #(.DATA_W(8), .PARITY(1), .STOP_BITS(1)) dut_e (
    .clock(clock), .reset(reset), .bus(bus_e));
  uart_frame_shifter #(.DATA_W(8), .PARITY(2), .STOP_BITS(1)) dut_o (
    .clock(clock), .reset(reset), .bus(bus_o));
  uart_frame_shifter #(.DATA_W(8), .PARITY(1), .STOP_BITS(2)) dut_2 (
    .clock(clock), .reset(reset), .bus(bus_2));

  logic       cur_tx, cur_busy, cur_done, cur_pe, cur_fe;
  logic [7:0] cur_dr;

  always_comb begin
    cur_tx = bus_e.tx_data;  cur_busy = bus_e.busy;  cur_done = bus_e.done;
    cur_dr = bus_e.data_received;  cur_pe = bus_e.rx_parity_err;  cur_fe = bus_e.rx_framing_err;
    if (sel == 1) begin
      cur_tx = bus_o.tx_data;  cur_busy = bus_o.busy;  cur_done = bus_o.done;
      cur_dr = bus_o.data_received;  cur_pe = bus_o.rx_parity_err;  cur_fe = bus_o.rx_framing_err;
    end else if (sel == 2) begin
      cur_tx = bus_2.tx_data;  cur_busy = bus_2.busy;  cur_done = bus_2.done;
      cur_dr = bus_2.data_received;  cur_pe = bus_2.rx_parity_err;  cur_fe = bus_2.rx_framing_err;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (sel=%0d t=%0t)", tag, got, exp, sel, $time);
  endtask

  // Transmitted frame, bit 0 first; bits above the frame width are ones.
  function automatic logic [11:0] model(input logic [7:0] d, input int cfg);
    logic [11:0] f;
    f      = 12'hFFF;
    f[0]   = 1'b0;
    f[8:1] = d;
    f[9]   = (^d) ^ (cfg == 1);
    return f;
  endfunction

  always @(negedge clock) begin
    if (reset && cur_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rx_data", {24'd0, cur_dr}, {24'd0, e.dr});
        check("rx_parity_err", {31'd0, cur_pe}, {31'd0, e.pe});
        check("rx_framing_err", {31'd0, cur_fe}, {31'd0, e.fe});
        $display("frame done sel=%0d data_received=%02h perr=%0b ferr=%0b", sel, cur_dr, cur_pe, cur_fe);
      end
    end
  end

  task automatic run_frame(input logic [7:0] d, input int flip_idx, input bit with_shift,
                           input bit busy_loads, input bit gap);
    logic [11:0] f, r;
    int          fw;
    exp_t        e;
    fw = (sel == 2) ? 12 : 11;
    f  = model(d, sel);
    r  = f;
    if (flip_idx >= 0) r[flip_idx] = ~r[flip_idx];
    e.dr = r[8:1];
    e.pe = r[9] ^ (^r[8:1]) ^ (sel == 1);
    e.fe = r[0] | ~r[10] | ((sel == 2) & ~r[11]);
    exp_q.push_back(e);
    $display("load sel=%0d data=%02h flip=%0d", sel, d, flip_idx);
    data  = d;
    load  = 1'b1;
    shift = with_shift;
    @(negedge clock);
    load  = 1'b0;
    shift = 1'b0;
    data  = 8'h00;
    check("busy_after_load", {31'd0, cur_busy}, 32'd1);
    for (int k = 0; k < fw; k++) begin
      if (busy_loads && (k == 3 || k == 10)) begin
        load = 1'b1;
        data = 8'h3C;
      end
      flip = (k == flip_idx);
      check("busy_in_frame", {31'd0, cur_busy}, 32'd1);
      check($sformatf("tx_bit%0d", k), {31'd0, cur_tx}, {31'd0, f[k]});
      shift = 1'b1;
      @(negedge clock);
      shift = 1'b0;
      load  = 1'b0;
      flip  = 1'b0;
      if (k < fw - 1) @(negedge clock);
    end
    check("done_pulse", {31'd0, cur_done}, 32'd1);
    check("busy_end", {31'd0, cur_busy}, 32'd0);
    if (gap) begin
      @(negedge clock);
      check("done_one_cycle", {31'd0, cur_done}, 32'd0);
      check("scoreboard_drained", exp_q.size(), 32'd0);
    end
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (2) @(negedge clock);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #0;
      check("rst_tx", {31'd0, cur_tx}, 32'd1);
      check("rst_busy", {31'd0, cur_busy}, 32'd0);
      check("rst_done", {31'd0, cur_done}, 32'd0);
      check("rst_rx", {22'd0, cur_dr, cur_pe, cur_fe}, 32'd0);
    end
    sel = 0;
    @(negedge clock);
    reset = 1'b1;

    shift = 1'b1;
    @(negedge clock);
    shift = 1'b0;
    @(negedge clock);
    check("idle_shift_busy", {31'd0, cur_busy}, 32'd0);
    check("idle_shift_tx", {31'd0, cur_tx}, 32'd1);

    run_frame(8'hA5, -1, 1'b0, 1'b0, 1'b1);
    run_frame(8'h01, -1, 1'b0, 1'b0, 1'b1);
    run_frame(8'hA5, 9, 1'b0, 1'b0, 1'b1);
    run_frame(8'hA5, 10, 1'b0, 1'b0, 1'b1);
    run_frame(8'hA5, 0, 1'b0, 1'b0, 1'b1);
    run_frame(8'h5A, -1, 1'b0, 1'b0, 1'b0);
    run_frame(8'hC3, -1, 1'b0, 1'b0, 1'b1);
    run_frame(8'hA5, -1, 1'b1, 1'b1, 1'b1);

    // Abort mid-frame: reset must clear everything without a clock edge.
    data = 8'h96;
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;
    for (int k = 0; k < 5; k++) begin
      shift = 1'b1;
      @(negedge clock);
      shift = 1'b0;
      @(negedge clock);
    end
    check("pre_abort_busy", {31'd0, cur_busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    $display("mid-frame reset asserted at t=%0t", $time);
    check("abort_tx", {31'd0, cur_tx}, 32'd1);
    check("abort_busy", {31'd0, cur_busy}, 32'd0);
    check("abort_done", {31'd0, cur_done}, 32'd0);
    check("abort_rx", {22'd0, cur_dr, cur_pe, cur_fe}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) begin
      shift = 1'b1;
      @(negedge clock);
      shift = 1'b0;
      @(negedge clock);
    end
    check("post_reset_idle", {31'd0, cur_busy}, 32'd0);
    check("post_reset_tx", {31'd0, cur_tx}, 32'd1);
    run_frame(8'h3C, -1, 1'b0, 1'b0, 1'b1);

    sel = 1;
    @(negedge clock);
    run_frame(8'h01, -1, 1'b0, 1'b0, 1'b1);
    run_frame(8'hA5, -1, 1'b0, 1'b0, 1'b1);

    sel = 2;
    @(negedge clock);
    run_frame(8'hA5, -1, 1'b0, 1'b0, 1'b1);
    run_frame(8'hA5, 11, 1'b0, 1'b0, 1'b1);
    run_frame(8'hA5, 10, 1'b0, 1'b0, 1'b1);

    repeat (3) @(negedge clock);
    check("final_scoreboard", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_frame_shifter.md
UART_FRAME_SHIFTER -- requirements
Module: uart_frame_shifter

Interface
REQ-001 Parameter DATA_W, default 8, number of data bits per frame (legal 5..9).
REQ-002 Parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-003 Parameter STOP_BITS, default 1, stop bits per frame (legal 1 or 2).
REQ-004 Derived FRAME_W = 1 + DATA_W + (PARITY!=0 ? 1 : 0) + STOP_BITS; frame register width is FRAME_W, and the bit counter width is clog2(FRAME_W+1).
REQ-005 clock  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 data  input  DATA_W  parallel transmit word, sampled on an accepted load.
REQ-008 load  input  1  frame start request; accepted only in IDLE.
REQ-009 shift  input  1  bit-period strobe, one clock wide.
REQ-010 shift_in  input  1  serial input bit, sampled on an accepted shift.
REQ-011 tx_data  output  1  serial output, equal to frame_reg[0] in SHIFT and 1 otherwise.
REQ-012 busy  output  1  high while in SHIFT.
REQ-013 done  output  1  one-clock pulse marking frame completion.
REQ-014 data_received  output  DATA_W  captured data field of the shifted-in frame.
REQ-015 rx_parity_err  output  1  parity check result of the last captured frame.
REQ-016 rx_framing_err  output  1  start/stop check result of the last captured frame.

Function
REQ-017 The state machine SHALL have two states: IDLE and SHIFT.
REQ-018 In IDLE with load=1, the block SHALL load frame_reg, clear the bit counter and enter SHIFT on that edge; tx_data shows the start bit 0 from the next cycle.
REQ-019 Frame layout, LSB first: [0]=0 start, [DATA_W:1]=data, then the parity bit if PARITY!=0, then STOP_BITS ones in the top bits.
REQ-020 The parity bit SHALL be the XOR of data for even parity and its inverse for odd parity.
REQ-021 In SHIFT with shift=1, the block SHALL shift frame_reg right by one, place shift_in in frame_reg[FRAME_W-1] and increment the counter; each bit holds until the next strobe.
REQ-022 On the edge of the FRAME_W-th accepted shift, the block SHALL return to IDLE, drop busy, assert done for exactly one cycle and update the received outputs from the post-shift frame_reg in the same cycle.
REQ-023 Received outputs: data_received=frame_reg[DATA_W:1]; rx_parity_err=1 if PARITY!=0 and the parity bit mismatches the data per REQ-020, else 0; rx_framing_err=1 if bit[0]!=0 or any stop bit !=1.
REQ-024 The received outputs SHALL hold their values until the next completion or reset.
REQ-025 load while busy SHALL be ignored, and shift in IDLE SHALL be ignored.
REQ-026 When load and shift are both high in IDLE, load wins and the shift is discarded.
REQ-027 When load and shift are both high in SHIFT, the shift proceeds and the load is ignored.
REQ-028 A load in the cycle after done SHALL be accepted, giving back-to-back frames.

Reset
REQ-029 reset=0 SHALL immediately force IDLE, frame_reg to all ones, counter=0, tx_data=1, busy=0, done=0, data_received=0, rx_parity_err=0 and rx_framing_err=0, including mid-frame.
REQ-030 After reset releases, the block SHALL accept no shift until a new load.

Verification
REQ-031 8/even/1 (FRAME_W=11), load data=0xA5, shift_in tied to tx_data, 11 strobes -> tx_data sequence 0,1,0,1,0,0,1,0,1,0,1; done pulses once; data_received=0xA5; both error flags 0.
REQ-032 Same config, data=0x01 -> parity bit 1; rerun with PARITY=2 -> parity bit 0; loopback errors 0 in both cases.
REQ-033 Loopback with the parity bit inverted on shift_in -> rx_parity_err=1, rx_framing_err=0, data_received=0xA5.
REQ-034 shift_in=0 during the stop bit (or 1 during the start bit) -> rx_framing_err=1; with STOP_BITS=2, a failure of the second stop bit alone also flags it.
REQ-035 load pulsed at shift counts 3 and 10, plus load and shift together in IDLE -> frame unchanged, no counter advance on the IDLE shift, a single done.
REQ-036 reset=0 after 5 strobes -> tx_data=1 and busy=0 with no clock edge; outputs cleared; the next load produces a full clean frame.
